spi_master_param: RTL and testbench

- Parametrised SPI master. Serialises a DATA_W-bit word on MOSI while shifting in MISO, with a programmable SCLK divider and all four CPOL/CPHA modes.
- Successor to the fixed 8-bit free-running counter/SPI stubs.
- Sits between a valid/ready word source and the external SPI pins. Runs on the single system clock.

---
 rtl/spi_pkg.sv | 22 ++
 rtl/spi_clk_div.sv | 52 +++++
 rtl/spi_master_param.sv | 170 +++++++++++++++++
 tb/tb_spi_master_param.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the parametrised SPI master: FSM state codes,
// CPOL/CPHA mode constants and a helper giving the frame length in cycles.
package spi_pkg;

    typedef logic [1:0] spi_state_t;

    localparam spi_state_t ST_IDLE  = 2'd0;
    localparam spi_state_t ST_SETUP = 2'd1;
    localparam spi_state_t ST_XFER  = 2'd2;
    localparam spi_state_t ST_HOLD  = 2'd3;

    // Mode encoding is {cpol, cpha}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    function automatic int unsigned xfer_cycles(input int unsigned data_w, input int unsigned n);
        return (2 * data_w + 2) * ((n == 0) ? 1 : n);
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Loadable SCLK half-period down-counter with a tick strobe, plus a count of
// the SCLK edges produced in the current frame.
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int DIV_W  = 8,
    parameter int EDGE_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              run,
    input  logic              count_edge,
    input  logic [DIV_W-1:0]  n_val,
    output logic              tick,
    output logic [EDGE_W-1:0] edge_cnt
);

    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [EDGE_W-1:0] edge_q, edge_d;

    assign tick     = run && (cnt_q == '0);
    assign edge_cnt = edge_q;

    // The counter reloads itself on every tick so each phase is N cycles long
    always_comb begin
        cnt_d  = cnt_q;
        edge_d = edge_q;
        if (load) begin
            cnt_d  = n_val - 1'b1;
            edge_d = '0;
        end else if (tick) begin
            cnt_d = n_val - 1'b1;
            if (count_edge) begin
                edge_d = edge_q + 1'b1;
            end
        end else if (run) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            edge_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            edge_q <= edge_d;
        end
    end

endmodule

// File: rtl/spi_master_param.sv
// SPI master: takes a word on a valid/ready handshake and runs one
// SETUP/XFER/HOLD frame on the SPI pins in any CPOL/CPHA mode.
module spi_master_param
    import spi_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DIV_W     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              SCLK,
    output logic              CS,
    output logic              MOSI,
    input  logic              MISO
);

    localparam int EDGE_W = $clog2(2 * DATA_W) + 1;
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);

    spi_state_t        state_q, state_d;
    logic              cs_q, cs_d, sclk_q, sclk_d, mosi_q, mosi_d;
    logic              cpol_q, cpol_d, cpha_q, cpha_d;
    logic              rx_valid_q, rx_valid_d;
    logic [DIV_W-1:0]  n_q, n_d, n_in, n_sel;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
    logic              accept, tick, leading, last_edge, sample_lead, do_sample, do_shift;
    logic [EDGE_W-1:0] edge_cnt;

    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? w[DATA_W-1] : w[0];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
    endfunction

    assign tx_ready = (state_q == ST_IDLE);
    assign accept   = tx_valid && tx_ready;
    assign n_in     = (clk_div == '0) ? DIV_W'(1) : clk_div;
    assign n_sel    = accept ? n_in : n_q;

    assign leading     = ~edge_cnt[0];
    assign last_edge   = (edge_cnt == LAST_EDGE);
    assign sample_lead = ({cpol_q, cpha_q} == MODE0) || ({cpol_q, cpha_q} == MODE2);
    assign do_sample   = (leading == sample_lead);
    // CPHA=0 has already presented bit 0 at accept, so it never shifts after the final edge
    assign do_shift    = sample_lead ? (!leading && !last_edge) : leading;

    spi_clk_div #(
        .DIV_W  (DIV_W),
        .EDGE_W (EDGE_W)
    ) u_clk_div (
        .clk        (sys_clk),
        .rst_n      (sys_rst_n),
        .load       (accept),
        .run        (state_q != ST_IDLE),
        .count_edge (state_q == ST_XFER),
        .n_val      (n_sel),
        .tick       (tick),
        .edge_cnt   (edge_cnt)
    );

    always_comb begin
        state_d    = state_q;
        cs_d       = cs_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        n_d        = n_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SETUP;
                    cs_d    = 1'b0;
                    sclk_d  = cpol;
                    cpol_d  = cpol;
                    cpha_d  = cpha;
                    n_d     = n_in;
                    rx_sh_d = '0;
                    if (!cpha) begin
                        mosi_d  = first_bit(tx_data);
                        tx_sh_d = shift_out(tx_data);
                    end else begin
                        mosi_d  = 1'b0;
                        tx_sh_d = tx_data;
                    end
                end
            end
            ST_SETUP: begin
                if (tick) begin
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (tick) begin
                    sclk_d = ~sclk_q;
                    if (do_sample) begin
                        rx_sh_d = MSB_FIRST ? {rx_sh_q[DATA_W-2:0], MISO}
                                            : {MISO, rx_sh_q[DATA_W-1:1]};
                    end
                    if (do_shift) begin
                        mosi_d  = first_bit(tx_sh_q);
                        tx_sh_d = shift_out(tx_sh_q);
                    end
                    if (last_edge) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    state_d    = ST_IDLE;
                    cs_d       = 1'b1;
                    rx_valid_d = 1'b1;
                    rx_data_d  = rx_sh_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_IDLE;
            cs_q       <= 1'b1;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            n_q        <= DIV_W'(1);
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cs_q       <= cs_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            n_q        <= n_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign CS       = cs_q;
    assign SCLK     = sclk_q;
    assign MOSI     = mosi_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: an MSB-first and an LSB-first instance share
// one stimulus stream and are checked every cycle against a timeline model.
module tb_spi_master_param;

    logic       sys_clk, sys_rst_n;
    logic       cpol, cpha, tx_valid, miso_drv;
    logic [7:0] clk_div, tx_data;
    int         miso_sel;

    logic       tx_ready0, rx_valid0, sclk0, cs0, mosi0, miso0;
    logic       tx_ready1, rx_valid1, sclk1, cs1, mosi1, miso1;
    logic [7:0] rx_data0, rx_data1;

    logic [1:0] cs_w, sclk_w, mosi_w, miso_w, ready_w, rvalid_w;
    logic [7:0] rdata_w [2];

    int checks = 0;
    int errors = 0;

    // Behavioural model state, one slot per DUT (0 = MSB first, 1 = LSB first)
    bit         act_m  [2];
    int         t_m    [2];
    int         n_m    [2];
    int         smp_m  [2];
    bit         cpol_m [2];
    bit         cpha_m [2];
    bit         idle_m [2];
    logic [7:0] word_m [2];
    logic [7:0] rxexp_m[2];
    logic [7:0] last_m [2];

    assign miso0 = (miso_sel == 0) ? mosi0 : miso_drv;
    assign miso1 = (miso_sel == 0) ? mosi1 : miso_drv;

    assign cs_w     = {cs1, cs0};
    assign sclk_w   = {sclk1, sclk0};
    assign mosi_w   = {mosi1, mosi0};
    assign miso_w   = {miso1, miso0};
    assign ready_w  = {tx_ready1, tx_ready0};
    assign rvalid_w = {rx_valid1, rx_valid0};
    assign rdata_w[0] = rx_data0;
    assign rdata_w[1] = rx_data1;

    spi_master_param #(.DATA_W(8), .DIV_W(8), .MSB_FIRST(1'b1)) dut_msb (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .clk_div(clk_div), .cpol(cpol), .cpha(cpha),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready0), .rx_data(rx_data0),
        .rx_valid(rx_valid0), .SCLK(sclk0), .CS(cs0), .MOSI(mosi0), .MISO(miso0)
    );

    spi_master_param #(.DATA_W(8), .DIV_W(8), .MSB_FIRST(1'b0)) dut_lsb (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .clk_div(clk_div), .cpol(cpol), .cpha(cpha),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready1), .rx_data(rx_data1),
        .rx_valid(rx_valid1), .SCLK(sclk1), .CS(cs1), .MOSI(mosi1), .MISO(miso1)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // MISO source for the non-loopback patterns, changed just after each rising edge
    initial begin
        miso_drv = 1'b0;
        forever begin
            @(posedge sys_clk);
            #1;
            if (miso_sel == 2) miso_drv = 1'($urandom);
            else if (miso_sel == 1) miso_drv = 1'b1;
            else miso_drv = 1'b0;
        end
    end

    task automatic compareValue(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", nm, got, want, $time);
        end
    endtask

    // Per-cycle comparison of one DUT against the timeline model, then model advance
    task automatic checkOutput(input int d);
        int  len, e, k, j, pos;
        bit  rdy;
        if (!sys_rst_n) begin
            act_m[d]  = 1'b0;
            idle_m[d] = 1'b0;
            last_m[d] = 8'h00;
            compareValue("rst_cs", 32'(cs_w[d]), 32'd1);
            compareValue("rst_sclk", 32'(sclk_w[d]), 32'd0);
            compareValue("rst_mosi", 32'(mosi_w[d]), 32'd0);
            compareValue("rst_ready", 32'(ready_w[d]), 32'd1);
            compareValue("rst_rvalid", 32'(rvalid_w[d]), 32'd0);
            compareValue("rst_rdata", 32'(rdata_w[d]), 32'd0);
            return;
        end
        if (act_m[d]) begin
            len = 18 * n_m[d];
            if (t_m[d] < len) begin
                compareValue("busy_cs", 32'(cs_w[d]), 32'd0);
                compareValue("busy_ready", 32'(ready_w[d]), 32'd0);
                compareValue("busy_rvalid", 32'(rvalid_w[d]), 32'd0);
                compareValue("busy_rdata", 32'(rdata_w[d]), 32'(last_m[d]));
                e = t_m[d] / n_m[d] - 1;
                if (e < 0) e = 0;
                if (e > 16) e = 16;
                compareValue("busy_sclk", 32'(sclk_w[d]), 32'(cpol_m[d] ^ e[0]));
                if (((t_m[d] + 1) % n_m[d]) == 0) begin
                    k = (t_m[d] + 1) / n_m[d] - 1;
                    if (k >= 1 && k <= 16 && ((k % 2 == 1) == !cpha_m[d])) begin
                        j = cpha_m[d] ? (k / 2 - 1) : ((k - 1) / 2);
                        pos = (d == 0) ? (7 - j) : j;
                        compareValue("mosi_bit", 32'(mosi_w[d]), 32'(word_m[d][pos]));
                        pos = (d == 0) ? (7 - smp_m[d]) : smp_m[d];
                        rxexp_m[d][pos] = miso_w[d];
                        smp_m[d]++;
                    end
                end
            end else begin
                compareValue("done_cs", 32'(cs_w[d]), 32'd1);
                compareValue("done_ready", 32'(ready_w[d]), 32'd1);
                compareValue("done_rvalid", 32'(rvalid_w[d]), 32'd1);
                compareValue("done_rdata", 32'(rdata_w[d]), 32'(rxexp_m[d]));
                compareValue("done_sclk", 32'(sclk_w[d]), 32'(cpol_m[d]));
                last_m[d] = rxexp_m[d];
            end
        end else begin
            compareValue("idle_cs", 32'(cs_w[d]), 32'd1);
            compareValue("idle_ready", 32'(ready_w[d]), 32'd1);
            compareValue("idle_rvalid", 32'(rvalid_w[d]), 32'd0);
            compareValue("idle_rdata", 32'(rdata_w[d]), 32'(last_m[d]));
            compareValue("idle_sclk", 32'(sclk_w[d]), 32'(idle_m[d]));
        end
        rdy = !act_m[d] || (t_m[d] == 18 * n_m[d]);
        if (act_m[d] && t_m[d] == 18 * n_m[d]) act_m[d] = 1'b0;
        if (act_m[d]) t_m[d]++;
        if (tx_valid && rdy) begin
            act_m[d]   = 1'b1;
            t_m[d]     = 0;
            word_m[d]  = tx_data;
            cpol_m[d]  = cpol;
            cpha_m[d]  = cpha;
            idle_m[d]  = cpol;
            n_m[d]     = (clk_div == 8'd0) ? 1 : int'(clk_div);
            smp_m[d]   = 0;
            rxexp_m[d] = 8'h00;
        end
    endtask

    always @(negedge sys_clk) begin
        checkOutput(0);
        checkOutput(1);
    end

    // Waits from just after an accept edge until rx_valid, measuring latency and SCLK edges
    task automatic waitDone(output int lat, output int edges, output logic cs_t0,
                            output logic [7:0] r0, output logic [7:0] r1);
        logic prev;
        int   t;
        prev  = sclk0;
        edges = 0;
        t     = 0;
        cs_t0 = 1'b1;
        r0    = 8'h00;
        r1    = 8'h00;
        forever begin
            @(negedge sys_clk);
            if (t == 0) cs_t0 = cs0;
            if (sclk0 !== prev) edges++;
            prev = sclk0;
            if (rx_valid0) begin
                r0 = rx_data0;
                r1 = rx_data1;
                break;
            end
            t++;
            if (t > 2000) begin
                checks++;
                errors++;
                $display("[TB] FAIL rx_valid_timeout: got none expected pulse at %0t", $time);
                break;
            end
        end
        lat = t;
    endtask

    task automatic applyStimulus(input logic [7:0] word, input logic [1:0] mode, input logic [7:0] div,
                                 input int msel, input bit keep, input logic [7:0] next_word,
                                 output int lat, output int edges,
                                 output logic [7:0] r0, output logic [7:0] r1);
        int   n;
        logic cs_t0;
        @(posedge sys_clk);
        #1;
        tx_data  = word;
        cpol     = mode[1];
        cpha     = mode[0];
        clk_div  = div;
        miso_sel = msel;
        tx_valid = 1'b1;
        n = 0;
        @(negedge sys_clk);
        while (!tx_ready0 && n < 500) begin
            @(negedge sys_clk);
            n++;
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got tx_ready 0 expected 1 at %0t", $time);
        end
        @(posedge sys_clk);
        #1;
        if (keep) begin
            tx_data = next_word;
        end else begin
            tx_valid = 1'b0;
            cpol     = 1'($urandom);
            cpha     = 1'($urandom);
            clk_div  = 8'($urandom_range(0, 5));
            tx_data  = 8'($urandom);
        end
        waitDone(lat, edges, cs_t0, r0, r1);
    endtask

    initial begin
        int         lat, edges, n;
        logic       cs_t0;
        logic [7:0] r0, r1, w;
        logic [1:0] m;
        sys_rst_n = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        cpol      = 1'b0;
        cpha      = 1'b0;
        clk_div   = 8'd2;
        miso_sel  = 0;
        repeat (3) @(negedge sys_clk);
        #2;
        sys_rst_n = 1'b1;

        $display("[TB] mode 0 loopback, N=2, 0xA5");
        applyStimulus(8'hA5, 2'b00, 8'd2, 0, 1'b0, 8'h00, lat, edges, r0, r1);
        compareValue("m0_latency", 32'(lat), 32'd36);
        compareValue("m0_edges", 32'(edges), 32'd16);
        compareValue("m0_rx_msb", 32'(r0), 32'hA5);
        compareValue("m0_rx_lsb", 32'(r1), 32'hA5);

        $display("[TB] mode 3, MISO high, N=1, 0x3C");
        applyStimulus(8'h3C, 2'b11, 8'd1, 1, 1'b0, 8'h00, lat, edges, r0, r1);
        compareValue("m3_latency", 32'(lat), 32'd18);
        compareValue("m3_rx_msb", 32'(r0), 32'hFF);
        compareValue("m3_rx_lsb", 32'(r1), 32'hFF);
        @(negedge sys_clk);
        compareValue("m3_idle_sclk", 32'(sclk0), 32'd1);

        $display("[TB] mode 1 back-to-back 0x81 then 0x7E");
        applyStimulus(8'h81, 2'b01, 8'd1, 0, 1'b1, 8'h7E, lat, edges, r0, r1);
        compareValue("b2b_rx1_msb", 32'(r0), 32'h81);
        compareValue("b2b_rx1_lsb", 32'(r1), 32'h81);
        compareValue("b2b_gap_cs", 32'(cs1), 32'd1);
        @(posedge sys_clk);
        #1;
        tx_valid = 1'b0;
        waitDone(lat, edges, cs_t0, r0, r1);
        compareValue("b2b_cs_low_again", 32'(cs_t0), 32'd0);
        compareValue("b2b_latency", 32'(lat), 32'd18);
        compareValue("b2b_rx2_msb", 32'(r0), 32'h7E);
        compareValue("b2b_rx2_lsb", 32'(r1), 32'h7E);

        $display("[TB] clk_div 0 behaves as N=1");
        applyStimulus(8'hC3, 2'b00, 8'd0, 0, 1'b0, 8'h00, lat, edges, r0, r1);
        compareValue("div0_latency", 32'(lat), 32'd18);
        compareValue("div0_edges", 32'(edges), 32'd16);
        compareValue("div0_rx", 32'(r0), 32'hC3);

        $display("[TB] reset after the 5th SCLK edge");
        @(posedge sys_clk);
        #1;
        tx_data  = 8'hE7;
        cpol     = 1'b1;
        cpha     = 1'b0;
        clk_div  = 8'd1;
        miso_sel = 0;
        tx_valid = 1'b1;
        @(posedge sys_clk);
        #1;
        tx_valid = 1'b0;
        n = 0;
        edges = 0;
        r0 = {7'd0, sclk0};
        while (edges < 5 && n < 200) begin
            @(negedge sys_clk);
            if (sclk0 !== r0[0]) edges++;
            r0[0] = sclk0;
            n++;
        end
        compareValue("rst_edges_seen", 32'(edges), 32'd5);
        #2;
        sys_rst_n = 1'b0;
        #1;
        compareValue("rst_now_cs", 32'(cs0), 32'd1);
        compareValue("rst_now_sclk", 32'(sclk0), 32'd0);
        compareValue("rst_now_ready", 32'(tx_ready0), 32'd1);
        compareValue("rst_now_rvalid", 32'(rx_valid0), 32'd0);
        repeat (2) @(negedge sys_clk);
        #2;
        sys_rst_n = 1'b1;
        applyStimulus(8'h55, 2'b00, 8'd2, 0, 1'b0, 8'h00, lat, edges, r0, r1);
        compareValue("post_rst_rx_msb", 32'(r0), 32'h55);
        compareValue("post_rst_rx_lsb", 32'(r1), 32'h55);
        compareValue("post_rst_latency", 32'(lat), 32'd36);

        $display("[TB] mode 2, N=3, inputs disturbed during the frame");
        applyStimulus(8'h96, 2'b10, 8'd3, 0, 1'b0, 8'h00, lat, edges, r0, r1);
        compareValue("latch_latency", 32'(lat), 32'd54);
        compareValue("latch_edges", 32'(edges), 32'd16);
        compareValue("latch_rx", 32'(r0), 32'h96);
        @(negedge sys_clk);
        compareValue("latch_idle_sclk", 32'(sclk0), 32'd1);

        $display("[TB] randomized transfers");
        for (int i = 0; i < 40; i++) begin
            w = 8'($urandom);
            m = 2'($urandom);
            n = $urandom_range(0, 2);
            applyStimulus(w, m, 8'($urandom_range(0, 3)), n, 1'b0, 8'h00, lat, edges, r0, r1);
            compareValue("rand_edges", 32'(edges), 32'd16);
            if (n == 0) begin
                compareValue("rand_loop_rx_msb", 32'(r0), 32'(w));
                compareValue("rand_loop_rx_lsb", 32'(r1), 32'(w));
            end
        end

        repeat (3) @(negedge sys_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
